// File: rtl/sprite_plotter.sv
// sprite_plotter: erases the previous positions of up to NUM_SPR fixed-size
// sprites and redraws them at freshly latched positions, emitting one pixel
// per clock to a VGA-adapter style write port (x, y, colour, plot).
//
// Ports:
//   CLOCK_50           sole clock, rising edge
//   resetn             asynchronous active-low reset
//   start              request one frame update (sampled only when idle)
//   spr_x/spr_y        packed per-sprite top-left coordinates (8/7 bits each)
//   spr_col / spr_en   packed per-sprite colour (3 bits) and enable
//   x, y, colour, plot registered pixel write port
//   busy               high from LATCH through DONE
//   done               one-cycle pulse after the update completes
//   collide            sprite-0 overlap flags
//
// Optional feature: define SPR_COLLIDE_EN to build the overlap comparators;
// otherwise collide is tied to zero.
module sprite_plotter #(
    parameter int unsigned NUM_SPR   = 2,
    parameter int unsigned SPR_W     = 4,
    parameter int unsigned SPR_H     = 4,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [NUM_SPR*8-1:0]   spr_x,
    input  logic [NUM_SPR*7-1:0]   spr_y,
    input  logic [NUM_SPR*3-1:0]   spr_col,
    input  logic [NUM_SPR-1:0]     spr_en,
    output logic [7:0]             x,
    output logic [6:0]             y,
    output logic [2:0]             colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_SPR-1:0]     collide
);

    localparam int unsigned IDX_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
    localparam int unsigned CX_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned CY_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_ERASE, S_DRAW, S_DONE} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [CX_W-1:0]        cx;
    logic [CY_W-1:0]        cy;
    logic [NUM_SPR*8-1:0]   snap_x, prev_x;
    logic [NUM_SPR*7-1:0]   snap_y, prev_y;
    logic [NUM_SPR*3-1:0]   snap_col;
    logic [NUM_SPR-1:0]     snap_en, prev_en;

    logic [7:0]             sel_x;
    logic [6:0]             sel_y;
    logic [2:0]             sel_col;
    logic [8:0]             sum_x;
    logic [7:0]             sum_y;
    logic                   pix_ok;
    logic                   last_col, last_row;
    logic [IDX_W:0]         first_prev, first_snap, nxt_prev, nxt_snap;

    // Lowest set bit of m at index >= lo, returned as {found, index}.
    function automatic logic [IDX_W:0] find_from(input logic [NUM_SPR-1:0] m, input int lo);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (m[i] && (i >= lo)) r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

    // Current pixel: ERASE reads the previous-position store, DRAW the snapshot.
    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_col = BG_COLOUR;
        for (int i = 0; i < NUM_SPR; i++) begin
            if (idx == IDX_W'(i)) begin
                if (state == S_ERASE) begin
                    sel_x = prev_x[8*i +: 8];
                    sel_y = prev_y[7*i +: 7];
                end else begin
                    sel_x   = snap_x[8*i +: 8];
                    sel_y   = snap_y[7*i +: 7];
                    sel_col = snap_col[3*i +: 3];
                end
            end
        end
        // Widened sums so a carry out of the coordinate is clipped, not wrapped.
        sum_x      = 9'(sel_x) + 9'(cx);
        sum_y      = 8'(sel_y) + 8'(cy);
        pix_ok     = (sum_x <= 9'd159) && (sum_y <= 8'd119);
        last_col   = (cx == CX_W'(SPR_W - 1));
        last_row   = (cy == CY_W'(SPR_H - 1));
        first_prev = find_from(prev_en, 0);
        first_snap = find_from(snap_en, 0);
        nxt_prev   = find_from(prev_en, int'(idx) + 1);
        nxt_snap   = find_from(snap_en, int'(idx) + 1);
    end

    // Update sequencer with registered pixel port and status outputs.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            idx      <= '0;
            cx       <= '0;
            cy       <= '0;
            snap_x   <= '0;
            snap_y   <= '0;
            snap_col <= '0;
            snap_en  <= '0;
            prev_x   <= '0;
            prev_y   <= '0;
            prev_en  <= '0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            plot     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            plot <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        snap_x   <= spr_x;
                        snap_y   <= spr_y;
                        snap_col <= spr_col;
                        snap_en  <= spr_en;
                        busy     <= 1'b1;
                        state    <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    cx <= '0;
                    cy <= '0;
                    if (first_prev[IDX_W]) begin
                        idx   <= first_prev[IDX_W-1:0];
                        state <= S_ERASE;
                    end else if (first_snap[IDX_W]) begin
                        idx   <= first_snap[IDX_W-1:0];
                        state <= S_DRAW;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_ERASE, S_DRAW: begin
                    x      <= sum_x[7:0];
                    y      <= sum_y[6:0];
                    colour <= sel_col;
                    plot   <= pix_ok;
                    if (!last_col) begin
                        cx <= cx + 1'b1;
                    end else begin
                        cx <= '0;
                        if (!last_row) begin
                            cy <= cy + 1'b1;
                        end else begin
                            cy <= '0;
                            // Sprite finished: hop to the next enabled one or next phase.
                            if (state == S_ERASE) begin
                                if (nxt_prev[IDX_W]) begin
                                    idx <= nxt_prev[IDX_W-1:0];
                                end else if (first_snap[IDX_W]) begin
                                    idx   <= first_snap[IDX_W-1:0];
                                    state <= S_DRAW;
                                end else begin
                                    state <= S_DONE;
                                end
                            end else begin
                                if (nxt_snap[IDX_W]) idx <= nxt_snap[IDX_W-1:0];
                                else                 state <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    prev_x  <= snap_x;
                    prev_y  <= snap_y;
                    prev_en <= snap_en;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SPR_COLLIDE_EN
    logic [NUM_SPR-1:0] coll_c;

    // Box overlap of sprite 0 against each other enabled sprite.
    always_comb begin
        coll_c = '0;
        for (int i = 1; i < NUM_SPR; i++) begin
            coll_c[i] = snap_en[0] && snap_en[i]
                && (9'(snap_x[7:0]) < 9'(snap_x[8*i +: 8]) + 9'(SPR_W))
                && (9'(snap_x[8*i +: 8]) < 9'(snap_x[7:0]) + 9'(SPR_W))
                && (8'(snap_y[6:0]) < 8'(snap_y[7*i +: 7]) + 8'(SPR_H))
                && (8'(snap_y[7*i +: 7]) < 8'(snap_y[6:0]) + 8'(SPR_H));
            coll_c[0] = coll_c[0] | coll_c[i];
        end
    end

    // Flags refresh only in LATCH and hold across the rest of the update.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)                collide <= '0;
        else if (state == S_LATCH)  collide <= coll_c;
    end
`else
    assign collide = '0;
`endif

endmodule

// File: tb/tb_sprite_plotter.sv
// Bench for sprite_plotter: a frame-level model lists every pixel the update
// must walk (erase boxes, then draw boxes) and the per-cycle checker compares
// plot/x/y/colour/busy/done against that list, plus literal anchor values.
module tb_sprite_plotter;

    localparam int NSPR = 2;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int BG   = 0;

    logic                CLOCK_50 = 1'b0;
    logic                resetn;
    logic                start;
    logic [NSPR*8-1:0]   spr_x;
    logic [NSPR*7-1:0]   spr_y;
    logic [NSPR*3-1:0]   spr_col;
    logic [NSPR-1:0]     spr_en;
    logic [7:0]          x;
    logic [6:0]          y;
    logic [2:0]          colour;
    logic                plot;
    logic                busy;
    logic                done;
    logic [NSPR-1:0]     collide;

    int errors = 0;
    int checks = 0;

    int sx[NSPR], sy[NSPR], scol[NSPR];
    bit sen[NSPR];
    int m_prev_x[NSPR], m_prev_y[NSPR];
    bit m_prev_en[NSPR];

    bit q_ok[$];
    int q_x[$], q_y[$], q_c[$];

    int done_t, seen_plots, done_count, first_x, first_y, last_col, exp_c;

    sprite_plotter dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .start    (start),
        .spr_x    (spr_x),
        .spr_y    (spr_y),
        .spr_col  (spr_col),
        .spr_en   (spr_en),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .done     (done),
        .collide  (collide)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NSPR; i++) begin
            spr_x[8*i +: 8]   = 8'(sx[i]);
            spr_y[7*i +: 7]   = 7'(sy[i]);
            spr_col[3*i +: 3] = 3'(scol[i]);
            spr_en[i]         = sen[i];
        end
    endtask

    task automatic add_box(input int bx, input int by, input int c);
        for (int r = 0; r < H; r++) begin
            for (int cc = 0; cc < W; cc++) begin
                q_ok.push_back((bx + cc <= 159) && (by + r <= 119));
                q_x.push_back(bx + cc);
                q_y.push_back(by + r);
                q_c.push_back(c);
            end
        end
    endtask

    // Every pixel the update walks, in order: old boxes in BG, then new boxes.
    task automatic build_expect();
        q_ok.delete(); q_x.delete(); q_y.delete(); q_c.delete();
        for (int i = 0; i < NSPR; i++)
            if (m_prev_en[i]) add_box(m_prev_x[i], m_prev_y[i], BG);
        for (int i = 0; i < NSPR; i++)
            if (sen[i]) add_box(sx[i], sy[i], scol[i]);
    endtask

    function automatic int model_collide();
        int c;
        c = 0;
`ifdef SPR_COLLIDE_EN
        for (int i = 1; i < NSPR; i++)
            if (sen[0] && sen[i] && (sx[0] - sx[i] < W) && (sx[i] - sx[0] < W)
                && (sy[0] - sy[i] < H) && (sy[i] - sy[0] < H))
                c = c | (1 << i);
        if (c != 0) c = c | 1;
`endif
        return c;
    endfunction

    // One start pulse, then per-cycle checks until a few cycles past the expected done.
    task automatic run_update(input int extra_t);
        int n, lat, idx;
        bit eplot;
        build_expect();
        n   = q_ok.size();
        lat = 2 + n;
        drive_inputs();
        seen_plots = 0; done_count = 0; done_t = -1;
        first_x = -1; first_y = -1; last_col = -1;
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        chk("busy_t0", int'(busy), 1);
        chk("plot_t0", int'(plot), 0);
        for (int t = 1; t <= lat + 4; t++) begin
            @(negedge CLOCK_50);
            start = 1'b0;
            idx   = t - 2;
            eplot = (idx >= 0 && idx < n) ? q_ok[idx] : 1'b0;
            chk("plot", int'(plot), int'(eplot));
            if (eplot && plot) begin
                chk("x", int'(x), q_x[idx]);
                chk("y", int'(y), q_y[idx]);
                chk("colour", int'(colour), q_c[idx]);
            end
            chk("done", int'(done), int'(t == lat));
            chk("busy", int'(busy), int'(t < lat));
            if (plot) begin
                if (seen_plots == 0) begin first_x = int'(x); first_y = int'(y); end
                seen_plots++;
                last_col = int'(colour);
            end
            if (done) begin done_count++; done_t = t; end
            if (t == extra_t) start = 1'b1;
        end
        chk("collide", int'(collide), model_collide());
        for (int i = 0; i < NSPR; i++) begin
            m_prev_x[i] = sx[i]; m_prev_y[i] = sy[i]; m_prev_en[i] = sen[i];
        end
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        for (int i = 0; i < NSPR; i++) begin
            sx[i] = 0; sy[i] = 0; scol[i] = 0; sen[i] = 0;
            m_prev_x[i] = 0; m_prev_y[i] = 0; m_prev_en[i] = 0;
        end
        drive_inputs();
        #12;
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_collide", int'(collide), 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        @(negedge CLOCK_50);

        // First update after reset: draw only.
        sx[0] = 10; sy[0] = 20; scol[0] = 4; sen[0] = 1; sen[1] = 0;
        run_update(-1);
        chk("lat_first", done_t, 18);
        chk("plots_first", seen_plots, 16);
        chk("first_x", first_x, 10);
        chk("first_y", first_y, 20);
        chk("first_colour", last_col, 4);

        // Move by one pixel: erase old box then draw new one.
        sx[0] = 11;
        run_update(-1);
        chk("lat_move", done_t, 34);
        chk("plots_move", seen_plots, 32);

        // Two sprites on the same box: sprite 1 ends on top.
        sx[0] = 50; sy[0] = 50; scol[0] = 1; sen[0] = 1;
        sx[1] = 50; sy[1] = 50; scol[1] = 2; sen[1] = 1;
        run_update(-1);
        chk("lat_two", done_t, 50);
        chk("top_colour", last_col, 2);
`ifdef SPR_COLLIDE_EN
        exp_c = 3;
`else
        exp_c = 0;
`endif
        chk("collide_lit", int'(collide), exp_c);

        // Extra start during DRAW must be ignored.
        sen[0] = 0; sx[1] = 100; sy[1] = 30; scol[1] = 6;
        run_update(40);
        chk("single_done", done_count, 1);
        chk("lat_ignore", done_t, 50);

        // Reset in the middle of ERASE.
        sx[0] = 10; sy[0] = 20; scol[0] = 4; sen[0] = 1; sen[1] = 0;
        drive_inputs();
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        chk("plot_pre_reset", int'(plot), 1);
        #2 resetn = 1'b0;
        #1;
        chk("abort_plot", int'(plot), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_x", int'(x), 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        for (int i = 0; i < NSPR; i++) m_prev_en[i] = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLOCK_50);
            chk("idle_plot", int'(plot), 0);
            chk("idle_busy", int'(busy), 0);
        end

        // Corner box after reset: no erase, only 4 visible pixels.
        sx[0] = 158; sy[0] = 118; scol[0] = 5; sen[0] = 1; sen[1] = 0;
        run_update(-1);
        chk("lat_corner", done_t, 18);
        chk("plots_corner", seen_plots, 4);

        // Coordinate carry beyond 8/7 bits must clip, not wrap.
        sx[0] = 254; sy[0] = 126; scol[0] = 3;
        run_update(-1);
        chk("lat_carry", done_t, 34);
        chk("plots_carry", seen_plots, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_plotter.md
SPRITE_PLOTTER -- requirements
Module: sprite_plotter

Interface
REQ-001 Parameters (one per line: name, default, meaning):
- NUM_SPR, 2, number of sprite channels (1..8).
- SPR_W, 4, sprite width in pixels (1..16).
- SPR_H, 4, sprite height in pixels (1..16).
- BG_COLOUR, 3'b000, colour written when erasing.
REQ-002 Ports (one per line: name, direction, width, meaning):
- CLOCK_50, in, 1, sole clock, rising edge.
- resetn, in, 1, asynchronous active-low reset.
- start, in, 1, request one frame update; sampled only in IDLE.
- spr_x, in, NUM_SPR*8, per-sprite top-left X; channel i at [8i+7:8i].
- spr_y, in, NUM_SPR*7, per-sprite top-left Y; channel i at [7i+6:7i].
- spr_col, in, NUM_SPR*3, per-sprite fill colour.
- spr_en, in, NUM_SPR, per-sprite enable.
- x, out, 8, VGA adapter pixel X.
- y, out, 7, VGA adapter pixel Y.
- colour, out, 3, VGA adapter pixel colour.
- plot, out, 1, VGA adapter write strobe.
- busy, out, 1, high from the LATCH state through the DONE state inclusive.
- done, out, 1, one-cycle pulse at frame-update completion.
- collide, out, NUM_SPR, overlap flags (see Configuration).

Function
REQ-003 FSM states: IDLE, LATCH, ERASE, DRAW, DONE; one pixel per cycle in ERASE and DRAW.
REQ-004 IDLE and start=1 -> LATCH; start while busy is ignored, not queued.
REQ-005 LATCH (one cycle) snapshots spr_x, spr_y, spr_col and spr_en into internal copies; input changes after LATCH do not affect the current update.
REQ-006 ERASE walks every sprite that was enabled in the previous update, in index order, covering SPR_W*SPR_H pixels row-major, with colour=BG_COLOUR.
REQ-007 DRAW walks every sprite enabled in the current snapshot in ascending index order, row-major, with colour=spr_col[i]; a higher index overwrites a lower one (drawn on top).
REQ-008 Disabled sprites consume zero cycles in ERASE and DRAW; if no sprite qualifies, that state is skipped.
REQ-009 x, y and colour are registered; plot is asserted in the same cycle as the pixel's x, y and colour.
REQ-010 A pixel with x>159 or y>119, including coordinate-sum carry beyond 8/7 bits, consumes its cycle with plot=0 (clipped, no wrap-around).
REQ-011 DONE (one cycle): done=1, previous-position store updated from the snapshot, then -> IDLE.
REQ-012 Total latency from start to done = 2 + (enabled previous sprites + enabled current sprites)*SPR_W*SPR_H cycles.
REQ-013 First update after reset performs no erase (no previous positions valid).

Reset
REQ-014 resetn=0 asynchronously forces IDLE, plot=0, done=0, busy=0, x=0, y=0, colour=0, collide=0, and all previous-valid flags to 0.
REQ-015 Reset mid-ERASE or mid-DRAW abandons the update; no further plot pulses occur until a new start after release.

Configuration
REQ-016 Macro SPR_COLLIDE_EN defined: during LATCH, collide[i] is set for i>=1 when sprites 0 and i are both enabled and their SPR_W x SPR_H boxes overlap by at least one pixel; collide[0]=|collide[NUM_SPR-1:1]; collide holds until the next LATCH.
REQ-017 SPR_COLLIDE_EN undefined: collide is tied to 0 and no comparator logic is synthesised.

Verification
REQ-018 Reset, then start with sprite 0 at (10,20), colour 3'b100, sprite 1 disabled -> 16 plots covering x 10..13, y 20..23, colour 100; done exactly 18 cycles after start.
REQ-019 Second start with sprite 0 moved to (11,20) -> 16 BG_COLOUR plots at the old box, then 16 plots at the new box; latency 34 cycles.
REQ-020 Sprite 0 at (158,118) -> only 4 plot pulses, (158..159, 118..119); latency unchanged at 18 cycles.
REQ-021 Sprites 0 and 1 both at (50,50) with SPR_COLLIDE_EN defined -> collide=2'b11 and the final plots at the box carry colour spr_col[1]; with the macro undefined -> collide=2'b00.
REQ-022 start pulsed again during DRAW -> ignored, a single done; resetn pulsed low mid-ERASE -> plot drops immediately, busy=0, and the next update performs no erase.
